// File: rtl/inst_fetch_queue.sv
// Prefetching fetch front end: issues sequential word fetches and buffers
// returned instructions with PC+4 until the ID stage drains them.
module inst_fetch_queue #(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              deq_ready,
    output logic              deq_valid,
    output logic [31:0]       deq_inst,
    output logic [ADDR_W-1:0] deq_pc4
);

    localparam int unsigned       PW      = $clog2(DEPTH);
    localparam int unsigned       CW      = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    logic [31:0]       mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_pc4  [DEPTH];

    logic [CW:0] credit;
    logic        fire;
    logic        drop_rsp;
    logic        push;
    logic        pop;

    // Credits cover both buffered and outstanding words so a push never
    // finds the FIFO full.
    assign credit   = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req = rst && !redirect && (credit < {1'b0, DEPTH_C});
    assign imem_addr = fetch_pc_q;

    assign fire     = imem_req && imem_gnt;
    assign drop_rsp = imem_rvalid && (drop_q != '0);
    assign push     = imem_rvalid && (drop_q == '0) && !redirect;
    assign deq_valid = (count_q != '0);
    assign pop      = deq_valid && deq_ready && !redirect;

    assign deq_inst = deq_valid ? mem_inst[rd_ptr_q] : '0;
    assign deq_pc4  = deq_valid ? mem_pc4[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + CW'(fire) - CW'(imem_rvalid);
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Everything still outstanding after this edge is stale.
            drop_d     = inflight_q - CW'(imem_rvalid);
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (drop_rsp) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + STEP;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr_q] <= imem_rdata;
            mem_pc4[wr_ptr_q]  <= resp_pc_q + STEP;
        end
    end

    // A kept response while full means the memory broke the protocol.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(imem_rvalid && (drop_q == '0) && (count_q == DEPTH_C))
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: memory model with in-order
// variable latency, scoreboard of expected instruction stream.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 3000;
    localparam int          RST_AT   = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    pend_t pend[$];
    exp_t  sb[$];
    int    tests  = 0;
    int    errors = 0;

    inst_fetch_queue #(
        .DEPTH(DEPTH),
        .ADDR_W(32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .deq_ready(deq_ready),
        .deq_valid(deq_valid),
        .deq_inst(deq_inst),
        .deq_pc4(deq_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares the FIFO head against the scoreboard and pops on dequeue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                if (deq_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL deq_unexpected: got pc4 %h expected none",
                                 deq_pc4);
                    end else begin
                        chk("deq_pc4", deq_pc4, sb[0].pc4);
                        chk("deq_inst", deq_inst, sb[0].inst);
                        if (deq_ready && !redirect) void'(sb.pop_front());
                    end
                end else begin
                    chk("idle_inst", deq_inst, 32'h0);
                    chk("idle_pc4", deq_pc4, 32'h0);
                end
            end
        end
    end

    // Stimulus and memory model.
    initial begin
        logic [31:0] next_fetch;
        int          last_due;
        int          lat;
        int          bubbles;
        bit          exp_req;
        pend_t       pe;

        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq_ready   = 1'b0;
        next_fetch  = RESET_PC;
        last_due    = 0;
        bubbles     = 0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(deq_valid), 32'h0);
        chk("rst_inst", deq_inst, 32'h0);
        chk("rst_pc4", deq_pc4, 32'h0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == 0 || cyc == RST_AT + 2) rst = 1'b1;

            if (cyc == RST_AT) begin
                rst         = 1'b0;
                imem_rvalid = 1'b0;
                redirect    = 1'b0;
                imem_gnt    = 1'b0;
                #1;
                chk("mid_rst_req", 32'(imem_req), 32'h0);
                chk("mid_rst_valid", 32'(deq_valid), 32'h0);
                chk("mid_rst_inst", deq_inst, 32'h0);
                chk("mid_rst_pc4", deq_pc4, 32'h0);
                pend.delete();
                sb.delete();
                next_fetch = RESET_PC;
                last_due   = 0;
                continue;
            end
            if (cyc == RST_AT + 1) continue;

            imem_rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
            imem_rdata  = imem_rvalid ? word_at(pend[0].addr) : $urandom;
            redirect_pc = $urandom;
            if (cyc < 40) begin
                imem_gnt  = 1'b1;
                deq_ready = 1'b1;
                redirect  = 1'b0;
                lat       = 1;
            end else if (cyc < 52) begin
                imem_gnt  = 1'b1;
                deq_ready = 1'b0;
                redirect  = 1'b0;
                lat       = 1;
            end else if (cyc < 60) begin
                imem_gnt  = 1'b1;
                deq_ready = 1'b1;
                redirect  = 1'b0;
                lat       = 3;
            end else begin
                imem_gnt  = ($urandom_range(0, 3) != 0);
                deq_ready = ($urandom_range(0, 3) != 0);
                redirect  = ($urandom_range(0, 11) == 0);
                lat       = $urandom_range(1, 4);
                if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
                if (cyc == 60 || cyc == 800) begin
                    redirect    = 1'b1;
                    redirect_pc = 32'hFFFF_FFF8;
                end
                if (cyc >= 300 && cyc < 305) imem_gnt = 1'b0;
            end

            #1;
            exp_req = !redirect && ((sb.size() + stale_cnt()) < DEPTH);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (imem_req) chk("imem_addr", imem_addr, next_fetch);
            if (cyc == 1) chk("first_valid_lo", 32'(deq_valid), 32'h0);
            if (cyc == 2) chk("first_valid_hi", 32'(deq_valid), 32'h1);
            if (cyc >= 2 && cyc < 40 && !deq_valid) bubbles++;
            if (cyc == 40) chk("throughput_bubbles", 32'(bubbles), 32'h0);

            #2;
            if (imem_rvalid) void'(pend.pop_front());
            if (redirect) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                sb.delete();
                next_fetch = redirect_pc;
            end else if (imem_req && imem_gnt) begin
                pe.addr  = next_fetch;
                pe.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pe.stale = 1'b0;
                last_due = pe.due;
                pend.push_back(pe);
                sb.push_back('{pc4: next_fetch + 32'd4,
                               inst: word_at(next_fetch)});
                next_fetch = next_fetch + 32'd4;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
